cpu_run_controller: RTL and testbench

Sequencer that owns the pipelined CPU's run lifecycle. It holds the core in reset, streams a program into instruction memory through a valid/ready port, and releases reset. It then counts execution cycles until `end_program`, lets the pipeline drain for a fixed number of cycles, and re-holds the core, flagging done or timeout. It sits between the system/host side and the `cpu_pipelined` instance, driving its reset and the imem write port.

---
 rtl/cpu_run_controller.sv | 125 ++++++++++++
 tb/tb_cpu_run_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Run-lifecycle sequencer for the pipelined CPU: holds the core in reset, loads imem
// through a valid/ready stream, runs until end_program (plus a drain window) or timeout.
module cpu_run_controller #(
    parameter int ADDR_W       = 8,
    parameter int DRAIN_CYCLES = 5,
    parameter int CNT_W        = 32,
    parameter int TIMEOUT      = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    input  logic              end_program,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    // state | meaning
    // IDLE  | core held in reset, waiting for start
    // LOAD  | accepting program words into imem
    // ARM   | final imem write lands, core still in reset
    // RUN   | core released, counting cycles
    // DRAIN | end_program seen, letting the pipeline empty
    // DONE  | core held in reset, results held
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_RUN, S_DRAIN, S_DONE
    } state_t;

    localparam int                  DRAIN_W   = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [DRAIN_W-1:0]  DRAIN_C   = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [ADDR_W-1:0]   PTR_MAX   = '1;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                handshake;
    logic [CNT_W-1:0]    cnt_inc;

    assign load_ready = (state == S_LOAD);
    assign handshake  = load_valid && load_ready;
    assign cnt_inc    = cycle_count + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ptr         <= '0;
            drain_cnt   <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            cpu_reset   <= 1'b1;
            cycle_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        ptr         <= '0;
                        cycle_count <= '0;
                        timeout     <= 1'b0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (handshake) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= load_data;
                        ptr        <= ptr + ADDR_W'(1);
                        // a full memory ends the load; the pointer is never reused
                        if (load_last || ptr == PTR_MAX) begin
                            state <= S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    state     <= S_RUN;
                    cpu_reset <= 1'b0;
                end
                S_RUN: begin
                    cycle_count <= cnt_inc;
                    if (end_program) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DRAIN_C;
                    end else if (cnt_inc == TIMEOUT_C) begin
                        state     <= S_DONE;
                        timeout   <= 1'b1;
                        done      <= 1'b1;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_W'(1)) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with a small imem (ADDR_W=3) and short timeout.
module tb_cpu_run_controller;

    localparam int ADDR_W  = 3;
    localparam int DRAIN   = 5;
    localparam int CNT_W   = 32;
    localparam int TMO     = 50;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              load_valid = 1'b0;
    logic [31:0]       load_data = '0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              end_program = 1'b0;
    logic [CNT_W-1:0]  cycle_count;
    logic              busy;
    logic              done;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    cpu_run_controller #(
        .ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .end_program(end_program),
        .cycle_count(cycle_count), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // reset values, checked before any clock edge
        #3 reset = 1'b1;
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_imem_we", imem_we, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_cpu_reset", cpu_reset, 1);

        // back-to-back load of 5 words, run 20 cycles, drain
        load_valid = 1'b1;
        tick();
        chk("idle_ignores_valid", imem_we, 0);
        load_valid = 1'b0;
        do_start();
        chk("load_ready", load_ready, 1);
        chk("load_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hA000_0000 + i;
            load_last  = (i == 4);
            tick();
            chk("b2b_we", imem_we, 1);
            chk("b2b_addr", imem_addr, i);
            chk("b2b_wdata", imem_wdata, 32'hA000_0000 + i);
            chk("b2b_ready", load_ready, (i < 4) ? 1 : 0);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("arm_cpu_reset", cpu_reset, 1);
        chk("arm_busy", busy, 1);
        tick();
        chk("run_cpu_reset", cpu_reset, 0);
        chk("run_we_low", imem_we, 0);
        chk("run_count0", cycle_count, 0);
        start = 1'b1;
        repeat (19) tick();
        start = 1'b0;
        chk("run_count19", cycle_count, 19);
        end_program = 1'b1;
        tick();
        end_program = 1'b0;
        chk("drain_count", cycle_count, 20);
        chk("drain_cpu_reset", cpu_reset, 0);
        repeat (4) tick();
        chk("drain_not_done", done, 0);
        chk("drain_count_frozen", cycle_count, 20);
        tick();
        chk("done", done, 1);
        chk("done_cpu_reset", cpu_reset, 1);
        chk("done_busy", busy, 0);
        chk("done_count", cycle_count, 20);
        chk("done_timeout", timeout, 0);

        // throttled load: a gap cycle after every word
        do_start();
        chk("restart_done_clr", done, 0);
        chk("restart_count_clr", cycle_count, 0);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h5500_0000 + (i * 3);
            load_last  = (i == 3);
            tick();
            chk("thr_we", imem_we, 1);
            chk("thr_addr", imem_addr, i);
            chk("thr_wdata", imem_wdata, 32'h5500_0000 + (i * 3));
            load_valid = 1'b0;
            load_last  = 1'b0;
            tick();
            chk("thr_gap_we", imem_we, 0);
            chk("thr_gap_addr", imem_addr, i);
        end
        chk("thr_run_cpu_reset", cpu_reset, 0);
        end_program = 1'b1;
        tick();
        end_program = 1'b0;
        chk("thr_count", cycle_count, 1);
        repeat (5) tick();
        chk("thr_done", done, 1);

        // full memory: 8 words, no load_last, then timeout
        do_start();
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hF000_0000 + i;
            tick();
            chk("full_addr", imem_addr, i);
        end
        load_data = 32'hDEAD_BEEF;
        chk("full_arm_ready", load_ready, 0);
        tick();
        chk("full_no_accept_we", imem_we, 0);
        chk("full_no_wrap", imem_addr, 7);
        chk("full_wdata_kept", imem_wdata, 32'hF000_0007);
        load_valid = 1'b0;
        chk("tmo_run_cpu_reset", cpu_reset, 0);
        repeat (49) tick();
        chk("tmo_count49", cycle_count, 49);
        chk("tmo_not_yet", timeout, 0);
        chk("tmo_cpu_reset_low", cpu_reset, 0);
        tick();
        chk("tmo_count", cycle_count, TMO);
        chk("tmo_flag", timeout, 1);
        chk("tmo_done", done, 1);
        chk("tmo_cpu_reset", cpu_reset, 1);
        repeat (3) tick();
        chk("tmo_sticky", timeout, 1);
        chk("tmo_count_hold", cycle_count, TMO);
        do_start();
        chk("tmo_clr_flag", timeout, 0);
        chk("tmo_clr_count", cycle_count, 0);
        chk("tmo_reload_ready", load_ready, 1);

        // abort during RUN
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h1234_0000 + i;
            load_last  = (i == 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        tick();
        repeat (10) tick();
        chk("abort_count10", cycle_count, 10);
        #2 reset = 1'b1;
        #1;
        chk("abort_cpu_reset", cpu_reset, 1);
        chk("abort_count", cycle_count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", imem_addr, 0);
        chk("abort_wdata", imem_wdata, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("abort_idle_ready", load_ready, 0);
        do_start();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h7700_0000 + i;
            load_last  = (i == 2);
            tick();
            chk("reload_addr", imem_addr, i);
            chk("reload_wdata", imem_wdata, 32'h7700_0000 + i);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        tick();
        chk("reload_run", cpu_reset, 0);

        // end_program on the TIMEOUT-th cycle wins over the timeout
        repeat (49) tick();
        end_program = 1'b1;
        tick();
        end_program = 1'b0;
        chk("tie_count", cycle_count, TMO);
        chk("tie_no_timeout", timeout, 0);
        chk("tie_not_done", done, 0);
        chk("tie_cpu_reset", cpu_reset, 0);
        repeat (5) tick();
        chk("tie_done", done, 1);
        chk("tie_timeout_clear", timeout, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
